// File: rtl/ascon_hash_ctrl.sv
// Ascon-Hash256 sequencer: drives one ascon_core through IV load, absorb, pad and squeeze.
// Message beats stream into S0; the 256-bit digest leaves as four 64-bit words.
module ascon_hash_ctrl #(
    parameter logic [63:0] IV = 64'h0000_0801_00CC_0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    input  logic [63:0] msg_data_i,
    input  logic        msg_last_i,
    input  logic [3:0]  msg_bytes_i,
    output logic        hash_valid_o,
    input  logic        hash_ready_i,
    output logic [63:0] hash_data_o,
    output logic        hash_last_o,
    output logic        core_start_o,
    output logic        core_rnd_cfg_o,
    output logic [2:0]  core_sel_o,
    output logic [63:0] core_wdata_o,
    output logic        core_we_o,
    output logic        core_xor_o,
    input  logic [63:0] core_rdata_i,
    input  logic        core_ready_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_ABSORB, S_PAD, S_SQUEEZE
    } state_t;

    state_t      state_q, state_d, ctx_q, ctx_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic        msg_ready_q, msg_ready_d;
    logic        hash_valid_q, hash_valid_d;
    logic        hash_last_q, hash_last_d;
    logic        start_q, start_d;
    logic        msg_hs, hash_hs;
    logic [3:0]  nbytes;
    logic [5:0]  pad_sh;
    logic [63:0] pad_bit, blk;

    assign msg_hs  = msg_valid_i && msg_ready_q;
    assign hash_hs = hash_valid_q && hash_ready_i;

    // Partial last beat: keep the valid bytes, put the 0x01 pad byte right after them.
    always_comb begin
        nbytes  = (msg_bytes_i > 4'd8) ? 4'd8 : msg_bytes_i;
        pad_sh  = {nbytes[2:0], 3'b000};
        pad_bit = 64'h1 << pad_sh;
        if (!msg_last_i || nbytes == 4'd8) blk = msg_data_i;
        else blk = (msg_data_i & (pad_bit - 64'h1)) | pad_bit;
    end

    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (msg_valid_i) begin
                    state_d = S_LOAD;
                    cnt_d   = 3'd0;
                end
            end
            S_LOAD: begin
                if (cnt_q == 3'd4) begin
                    cnt_d   = 3'd0;
                    state_d = S_START;
                    ctx_d   = S_ABSORB;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (core_ready_i) state_d = ctx_q;
            end
            S_ABSORB: begin
                if (msg_hs) begin
                    state_d = S_START;
                    if (!msg_last_i)         ctx_d = S_ABSORB;
                    else if (nbytes == 4'd8) ctx_d = S_PAD;
                    else                     ctx_d = S_SQUEEZE;
                end
            end
            S_PAD: begin
                state_d = S_START;
                ctx_d   = S_SQUEEZE;
            end
            S_SQUEEZE: begin
                if (hash_hs) begin
                    if (wcnt_q == 2'd3) begin
                        wcnt_d  = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        wcnt_d  = wcnt_q + 2'd1;
                        state_d = S_START;
                        ctx_d   = S_SQUEEZE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        msg_ready_d  = (state_d == S_ABSORB);
        hash_valid_d = (state_d == S_SQUEEZE);
        hash_last_d  = (state_d == S_SQUEEZE) && (wcnt_d == 2'd3);
        start_d      = (state_d == S_START);
    end

    // Write port is decoded from state so the absorb XOR lands in the handshake cycle itself.
    always_comb begin
        core_we_o    = 1'b0;
        core_xor_o   = 1'b0;
        core_sel_o   = 3'd0;
        core_wdata_o = 64'd0;
        case (state_q)
            S_LOAD: begin
                core_we_o    = 1'b1;
                core_sel_o   = cnt_q;
                core_wdata_o = (cnt_q == 3'd0) ? IV : 64'd0;
            end
            S_ABSORB: begin
                if (msg_hs) begin
                    core_we_o    = 1'b1;
                    core_xor_o   = 1'b1;
                    core_wdata_o = blk;
                end
            end
            S_PAD: begin
                core_we_o    = 1'b1;
                core_xor_o   = 1'b1;
                core_wdata_o = 64'h1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ctx_q        <= S_ABSORB;
            cnt_q        <= 3'd0;
            wcnt_q       <= 2'd0;
            msg_ready_q  <= 1'b0;
            hash_valid_q <= 1'b0;
            hash_last_q  <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctx_q        <= ctx_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            msg_ready_q  <= msg_ready_d;
            hash_valid_q <= hash_valid_d;
            hash_last_q  <= hash_last_d;
            start_q      <= start_d;
        end
    end

    assign msg_ready_o    = msg_ready_q;
    assign hash_valid_o   = hash_valid_q;
    assign hash_last_o    = hash_last_q;
    assign hash_data_o    = hash_valid_q ? core_rdata_i : 64'd0;
    assign core_start_o   = start_q;
    assign core_rnd_cfg_o = 1'b1;
endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// Bench for ascon_hash_ctrl: behavioural ascon_core plus a byte-level Ascon-Hash256 reference.
`timescale 1ns/1ps
module tb_ascon_hash_ctrl;
    localparam logic [63:0] IV = 64'h0000_0801_00CC_0002;
    typedef logic [4:0][63:0] st_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        msg_valid_i = 1'b0, msg_last_i = 1'b0, hash_ready_i = 1'b0;
    logic [63:0] msg_data_i = 64'd0;
    logic [3:0]  msg_bytes_i = 4'd0;
    logic        msg_ready_o, hash_valid_o, hash_last_o;
    logic [63:0] hash_data_o, core_wdata_o, core_rdata_i;
    logic        core_start_o, core_rnd_cfg_o, core_we_o, core_xor_o, core_ready_i;
    logic [2:0]  core_sel_o;

    int n_checks = 0, n_fail = 0, cyc = 0, wr_busy = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ascon_hash_ctrl #(.IV(IV)) dut (
        .clk(clk), .rst(rst),
        .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_data_i(msg_data_i),
        .msg_last_i(msg_last_i), .msg_bytes_i(msg_bytes_i),
        .hash_valid_o(hash_valid_o), .hash_ready_i(hash_ready_i), .hash_data_o(hash_data_o),
        .hash_last_o(hash_last_o),
        .core_start_o(core_start_o), .core_rnd_cfg_o(core_rnd_cfg_o), .core_sel_o(core_sel_o),
        .core_wdata_o(core_wdata_o), .core_we_o(core_we_o), .core_xor_o(core_xor_o),
        .core_rdata_i(core_rdata_i), .core_ready_i(core_ready_i)
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic st_t perm(input st_t s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        for (int r = 0; r < 12; r++) begin
            x2 ^= 64'((15 - r) * 16 + r);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= ror(x0, 19) ^ ror(x0, 28);
            x1 ^= ror(x1, 61) ^ ror(x1, 39);
            x2 ^= ror(x2, 1)  ^ ror(x2, 6);
            x3 ^= ror(x3, 10) ^ ror(x3, 17);
            x4 ^= ror(x4, 7)  ^ ror(x4, 41);
        end
        s[0] = x0; s[1] = x1; s[2] = x2; s[3] = x3; s[4] = x4;
        return s;
    endfunction

    // Reference Ascon-Hash256 over a byte string.
    function automatic logic [3:0][63:0] ref_hash(input logic [7:0] m[$]);
        st_t s;
        logic [63:0] w;
        logic [3:0][63:0] h;
        int L, nfull, r;
        L = m.size(); nfull = L / 8; r = L % 8;
        s = '0; s[0] = IV; s = perm(s);
        for (int i = 0; i < nfull; i++) begin
            w = 64'd0;
            for (int j = 0; j < 8; j++) w[8*j +: 8] = m[8*i + j];
            s[0] ^= w; s = perm(s);
        end
        w = 64'd0;
        for (int j = 0; j < r; j++) w[8*j +: 8] = m[8*nfull + j];
        w[8*r +: 8] = 8'h01;
        s[0] ^= w; s = perm(s);
        h[0] = s[0];
        for (int k = 1; k < 4; k++) begin s = perm(s); h[k] = s[0]; end
        return h;
    endfunction

    // Behavioural core: INIT one cycle after start, 12 PERM cycles, ready again 14 cycles after start.
    st_t cst;
    int  busy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cst  <= '0;
            busy <= 0;
        end else begin
            if (core_we_o) begin
                if (busy != 0 || core_sel_o > 3'd4) wr_busy <= wr_busy + 1;
                else cst[core_sel_o] <= core_xor_o ? (cst[core_sel_o] ^ core_wdata_o) : core_wdata_o;
            end
            if (core_start_o) begin
                cst  <= perm(cst);
                busy <= 13;
            end else if (busy > 0) begin
                busy <= busy - 1;
            end
        end
    end
    assign core_ready_i = (busy == 0);
    assign core_rdata_i = (core_sel_o < 3'd5) ? cst[core_sel_o] : 64'd0;

    logic [63:0] res_h [4];
    int          res_th [4];
    logic [3:0]  res_last;
    int          res_tready, res_bad, res_both;
    bit          res_timeout;
    logic [63:0] res_last_wr, res_last_data;

    task automatic drive_beat(input logic [7:0] m[$], input int i, input int nb, input bit big);
        int L, r;
        L = m.size();
        for (int j = 0; j < 8; j++)
            msg_data_i[8*j +: 8] = (8*i + j < L) ? m[8*i + j] : 8'($urandom);
        msg_last_i = (i == nb - 1);
        if (msg_last_i) begin
            r = L - 8*i;
            msg_bytes_i = (r == 8 && big) ? 4'($urandom_range(15, 8)) : 4'(r);
            res_last_data = msg_data_i;
        end else begin
            msg_bytes_i = 4'($urandom_range(15, 0));
        end
    endtask

    // Streams one message in and collects the digest; optional upstream stall and hash backpressure.
    task automatic run_msg(input logic [7:0] m[$], input int stall_beat, input int stall_cyc,
                           input int bp_word, input int bp_cyc, input bit big);
        int nb, bi, wi, t0, left, stall_cnt, bp_cnt;
        bit stall_pend, bp_done, hs_m, hs_h;
        logic [63:0] bp_ref;
        nb = (m.size() == 0) ? 1 : (m.size() + 7) / 8;
        bi = 0; wi = 0; stall_cnt = 0; bp_cnt = 0; stall_pend = 0; bp_done = 0;
        hs_m = 0; hs_h = 0; bp_ref = 64'd0;
        res_bad = 0; res_both = 0; res_tready = -1; res_last = 4'd0;
        @(negedge clk);
        t0 = cyc;
        drive_beat(m, 0, nb, big);
        msg_valid_i = 1'b1; hash_ready_i = 1'b1;
        left = 4000;
        while (wi < 4 && left > 0) begin
            @(negedge clk);
            left--;
            if (msg_ready_o && hash_valid_o) res_both++;
            if (core_we_o && core_xor_o) res_last_wr = core_wdata_o;
            if (hs_m) begin
                bi++;
                if (bi >= nb) msg_valid_i = 1'b0;
                else if (bi == stall_beat) begin msg_valid_i = 1'b0; stall_pend = 1; end
                else drive_beat(m, bi, nb, big);
            end
            if (hs_h) wi++;
            if (wi < 4) begin
                if (stall_cnt > 0) begin
                    if (!msg_ready_o || core_we_o || core_start_o) res_bad++;
                    stall_cnt--;
                    if (stall_cnt == 0) begin drive_beat(m, bi, nb, big); msg_valid_i = 1'b1; end
                end else if (stall_pend && msg_ready_o) begin
                    stall_pend = 0; stall_cnt = stall_cyc;
                end
                if (bp_cnt > 0) begin
                    if (hash_data_o !== bp_ref || !hash_valid_o || core_we_o || core_start_o) res_bad++;
                    bp_cnt--;
                    if (bp_cnt == 0) hash_ready_i = 1'b1;
                end else if (!bp_done && wi == bp_word && hash_valid_o) begin
                    bp_done = 1; bp_cnt = bp_cyc; hash_ready_i = 1'b0; bp_ref = hash_data_o;
                end
                hs_m = msg_valid_i && msg_ready_o;
                if (hs_m && res_tready < 0) res_tready = cyc - t0;
                hs_h = hash_valid_o && hash_ready_i;
                if (hs_h) begin
                    res_h[wi] = hash_data_o; res_th[wi] = cyc - t0; res_last[wi] = hash_last_o;
                end
            end
        end
        res_timeout = (wi < 4);
    endtask

    task automatic test_reset();
        int t0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({msg_ready_o, hash_valid_o, hash_last_o, core_start_o, core_we_o, core_xor_o,
             core_sel_o, core_wdata_o, hash_data_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        n_checks++;
        if (core_rnd_cfg_o !== 1'b1) begin
            n_fail++; $display("FAIL rnd_cfg: got %b required 1", core_rnd_cfg_o);
        end
        rst = 1'b0;
        @(negedge clk);
        t0 = cyc;
        msg_valid_i = 1'b1; msg_last_i = 1'b1; msg_bytes_i = 4'd0; msg_data_i = 64'($urandom);
        while (cyc < t0 + 6) @(negedge clk);
        n_checks++;
        if (core_start_o !== 1'b1) begin
            n_fail++; $display("FAIL first_start: got %b at cycle 6, required 1", core_start_o);
        end
        while (cyc < t0 + 10) @(negedge clk);
        n_checks++;
        if (core_ready_i !== 1'b0) begin
            n_fail++; $display("FAIL mid_wait: core ready %b, required 0", core_ready_i);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({msg_ready_o, hash_valid_o, hash_last_o, core_start_o, core_we_o, core_xor_o,
             core_sel_o, core_wdata_o, hash_data_o} !== '0) begin
            n_fail++; $display("FAIL async_reset: outputs not 0 before clock edge");
        end
        @(negedge clk);
        rst = 1'b0; msg_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({core_ready_i, msg_ready_o, hash_valid_o} !== 3'b100) begin
            n_fail++; $display("FAIL post_reset: ready/msg_ready/hash_valid %b required 100",
                               {core_ready_i, msg_ready_o, hash_valid_o});
        end
    endtask

    task automatic test_empty();
        logic [7:0] m[$];
        logic [3:0][63:0] exp;
        int tx [4];
        tx = '{37, 53, 69, 85};
        exp = ref_hash(m);
        run_msg(m, -1, 0, -1, 0, 0);
        n_checks++;
        if (res_timeout) begin n_fail++; $display("FAIL empty_timeout: digest incomplete"); end
        n_checks++;
        if (res_tready !== 21) begin
            n_fail++; $display("FAIL empty_accept: cycle %0d required 21", res_tready);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res_th[k] !== tx[k]) begin
                n_fail++; $display("FAIL empty_time_h%0d: cycle %0d required %0d", k, res_th[k], tx[k]);
            end
            n_checks++;
            if (res_h[k] !== exp[k]) begin
                n_fail++; $display("FAIL empty_h%0d: got %h required %h", k, res_h[k], exp[k]);
            end
        end
        n_checks++;
        if (res_last !== 4'b1000) begin
            n_fail++; $display("FAIL empty_last: got %b required 1000", res_last);
        end
    endtask

    task automatic test_pad8();
        logic [7:0] m[$];
        logic [3:0][63:0] exp;
        for (int i = 0; i < 8; i++) m.push_back(8'(i));
        exp = ref_hash(m);
        run_msg(m, -1, 0, -1, 0, 0);
        n_checks++;
        if (res_timeout || res_th[0] !== 53) begin
            n_fail++; $display("FAIL pad8_time: H0 cycle %0d required 53", res_th[0]);
        end
        n_checks++;
        if (res_last_wr !== 64'h1) begin
            n_fail++; $display("FAIL pad8_padwrite: got %h required 1", res_last_wr);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res_h[k] !== exp[k]) begin
                n_fail++; $display("FAIL pad8_h%0d: got %h required %h", k, res_h[k], exp[k]);
            end
        end
    endtask

    task automatic test_three_beats();
        logic [7:0] m[$];
        logic [3:0][63:0] exp;
        logic [63:0] blk;
        for (int i = 0; i < 21; i++) m.push_back(8'($urandom));
        exp = ref_hash(m);
        run_msg(m, -1, 0, -1, 0, 0);
        blk = (res_last_data & 64'hFF_FFFF_FFFF) | 64'h0100_0000_0000;
        n_checks++;
        if (res_last_wr !== blk) begin
            n_fail++; $display("FAIL three_lastblk: got %h required %h", res_last_wr, blk);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res_timeout || res_h[k] !== exp[k]) begin
                n_fail++; $display("FAIL three_h%0d: got %h required %h", k, res_h[k], exp[k]);
            end
        end
    endtask

    task automatic test_hash_backpressure();
        logic [7:0] m[$];
        logic [3:0][63:0] exp;
        int len;
        len = 8 + $urandom_range(0, 15);
        for (int i = 0; i < len; i++) m.push_back(8'($urandom));
        exp = ref_hash(m);
        run_msg(m, -1, 0, 1, 20, 0);
        n_checks++;
        if (res_timeout || res_bad !== 0) begin
            n_fail++; $display("FAIL bp_hold: %0d violations required 0", res_bad);
        end
        n_checks++;
        if (res_th[1] - res_th[0] !== 36) begin
            n_fail++; $display("FAIL bp_gap: %0d cycles required 36", res_th[1] - res_th[0]);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res_h[k] !== exp[k]) begin
                n_fail++; $display("FAIL bp_h%0d: got %h required %h", k, res_h[k], exp[k]);
            end
        end
    endtask

    task automatic test_upstream_stall();
        logic [7:0] m[$];
        logic [3:0][63:0] exp;
        int len;
        len = 24 + $urandom_range(0, 10);
        for (int i = 0; i < len; i++) m.push_back(8'($urandom));
        exp = ref_hash(m);
        run_msg(m, 1, 30, -1, 0, 0);
        n_checks++;
        if (res_timeout || res_bad !== 0) begin
            n_fail++; $display("FAIL stall_hold: %0d violations required 0", res_bad);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (res_h[k] !== exp[k]) begin
                n_fail++; $display("FAIL stall_h%0d: got %h required %h", k, res_h[k], exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m[$];
        logic [3:0][63:0] exp;
        int len;
        for (int t = 0; t < 6; t++) begin
            m.delete();
            len = (t == 0) ? 16 : $urandom_range(0, 40);
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            exp = ref_hash(m);
            run_msg(m, -1, 0, -1, 0, 1);
            n_checks++;
            if (res_timeout || res_tready !== 21 || res_both !== 0) begin
                n_fail++; $display("FAIL b2b%0d_flow: accept %0d required 21, overlap %0d required 0",
                                   t, res_tready, res_both);
            end
            n_checks++;
            if (res_h !== '{exp[0], exp[1], exp[2], exp[3]}) begin
                n_fail++; $display("FAIL b2b%0d_digest (len %0d): got %h required %h", t, len, res_h[0], exp[0]);
            end
        end
        n_checks++;
        if (wr_busy !== 0) begin
            n_fail++; $display("FAIL core_write_busy: %0d writes while busy, required 0", wr_busy);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_pad8();
        test_three_beats();
        test_hash_backpressure();
        test_upstream_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
